// File: rtl/serial_link_enqueue_arbiter_pkg.sv
// Shared types and helpers for the serial link enqueue arbiter.
package serial_link_enqueue_arbiter_pkg;

    typedef enum logic [0:0] {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    // Round-robin successor of a channel index, wrapping at num_chan.
    function automatic int unsigned rr_next(int unsigned idx, int unsigned num_chan);
        return (idx + 1 >= num_chan) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/serial_link_enqueue_arbiter_if.sv
// Per-channel source streams plus the single arbitrated stream towards the enqueue stage.
interface serial_link_enqueue_arbiter_if #(
    parameter int unsigned NumChan   = 5,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned StrbWidth = 8
);
    localparam int unsigned IdWidth = $clog2(NumChan);

    logic [NumChan-1:0]           valid_i;
    logic [NumChan-1:0]           ready_o;
    logic [NumChan-1:0]           last_i;
    logic [NumChan*DataWidth-1:0] data_i;
    logic [NumChan*StrbWidth-1:0] strb_i;
    logic                         valid_o;
    logic                         ready_i;
    logic [DataWidth-1:0]         data_o;
    logic [StrbWidth-1:0]         strb_o;
    logic [IdWidth-1:0]           chan_id_o;

    // Arbiter side.
    modport slave (
        input  valid_i, last_i, data_i, strb_i, ready_i,
        output ready_o, valid_o, data_o, strb_o, chan_id_o
    );

    // Source / enqueue-stage side.
    modport master (
        output valid_i, last_i, data_i, strb_i, ready_i,
        input  ready_o, valid_o, data_o, strb_o, chan_id_o
    );

endinterface

// File: rtl/serial_link_enqueue_arbiter_rr_select.sv
// Combinational rotating priority pick: first set request at or after ptr_i, wrapping.
module serial_link_enqueue_arbiter_rr_select #(
    parameter int unsigned NumChan = 5,
    parameter int unsigned IdWidth = $clog2(NumChan)
) (
    input  logic [NumChan-1:0] req_i,
    input  logic [IdWidth-1:0] ptr_i,
    output logic [IdWidth-1:0] idx_o,
    output logic               found_o
);

    int unsigned cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NumChan; k++) begin
            cand = (32'(ptr_i) + k) % NumChan;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = IdWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/serial_link_enqueue_arbiter.sv
// Packet-level locked round-robin arbiter in front of the serial link enqueue stage.
// Optional starvation boost enabled by defining SERIAL_LINK_ARB_STARVE_EN.
module serial_link_enqueue_arbiter
    import serial_link_enqueue_arbiter_pkg::*;
#(
    parameter int unsigned NumChan      = 5,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned StrbWidth    = 8,
    parameter int unsigned StarveCycles = 16
) (
    input logic                         clk_i,
    input logic                         rst_i,
    serial_link_enqueue_arbiter_if.slave bus
);

    localparam int unsigned IdWidth = $clog2(NumChan);

    arb_state_e         state_q, state_d;
    logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0] grant_q, grant_d;

    logic [IdWidth-1:0] rr_idx, sel_idx, cur_idx;
    logic               rr_found, sel_found, cur_vld, hs;

    logic                 valid_out;
    logic [NumChan-1:0]   ready_out;
    logic [DataWidth-1:0] data_out;
    logic [StrbWidth-1:0] strb_out;
    logic [IdWidth-1:0]   id_out;

    serial_link_enqueue_arbiter_rr_select #(
        .NumChan (NumChan),
        .IdWidth (IdWidth)
    ) u_rr_select (
        .req_i   (bus.valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

`ifdef SERIAL_LINK_ARB_STARVE_EN
    localparam int unsigned CntWidth = $clog2(StarveCycles + 1);

    logic [CntWidth-1:0] wait_q [NumChan];
    logic [NumChan-1:0]  starved, granted;
    logic [IdWidth-1:0]  starve_idx;
    logic                starve_found;

    always_comb begin
        starved = '0;
        granted = '0;
        for (int unsigned c = 0; c < NumChan; c++) begin
            starved[c] = bus.valid_i[c] && (32'(wait_q[c]) >= StarveCycles);
            granted[c] = (state_q == ArbLocked) ? (grant_q == IdWidth'(c))
                                                : (sel_found && sel_idx == IdWidth'(c));
        end
    end

    // Pointer fixed at zero gives lowest-index-wins among starved channels.
    serial_link_enqueue_arbiter_rr_select #(
        .NumChan (NumChan),
        .IdWidth (IdWidth)
    ) u_starve_select (
        .req_i   (starved),
        .ptr_i   ('0),
        .idx_o   (starve_idx),
        .found_o (starve_found)
    );

    assign sel_idx   = starve_found ? starve_idx : rr_idx;
    assign sel_found = starve_found | rr_found;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NumChan; c++) wait_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NumChan; c++) begin
                if (hs && cur_idx == IdWidth'(c) && bus.last_i[c]) begin
                    wait_q[c] <= '0;
                end else if (bus.valid_i[c] && !granted[c] && wait_q[c] != '1) begin
                    wait_q[c] <= wait_q[c] + 1'b1;
                end
            end
        end
    end
`else
    assign sel_idx   = rr_idx;
    assign sel_found = rr_found;
`endif

    // While locked the selection is frozen to the owner, even across bubbles.
    assign cur_idx = (state_q == ArbLocked) ? grant_q : sel_idx;
    assign cur_vld = (state_q == ArbLocked) ? bus.valid_i[grant_q] : sel_found;

    always_comb begin
        valid_out = 1'b0;
        ready_out = '0;
        data_out  = '0;
        strb_out  = '0;
        id_out    = '0;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;

        if (!rst_i && cur_vld) begin
            valid_out          = 1'b1;
            id_out             = cur_idx;
            data_out           = bus.data_i[32'(cur_idx)*DataWidth +: DataWidth];
            strb_out           = bus.strb_i[32'(cur_idx)*StrbWidth +: StrbWidth];
            ready_out[cur_idx] = bus.ready_i;
        end
        hs = valid_out && bus.ready_i;

        unique case (state_q)
            ArbIdle: begin
                if (cur_vld) begin
                    if (hs && bus.last_i[cur_idx]) begin
                        rr_ptr_d = IdWidth'(rr_next(32'(cur_idx), NumChan));
                    end else begin
                        state_d = ArbLocked;
                        grant_d = cur_idx;
                    end
                end
            end
            ArbLocked: begin
                if (hs && bus.last_i[grant_q]) begin
                    state_d  = ArbIdle;
                    rr_ptr_d = IdWidth'(rr_next(32'(grant_q), NumChan));
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.valid_o   = valid_out;
    assign bus.ready_o   = ready_out;
    assign bus.data_o    = data_out;
    assign bus.strb_o    = strb_out;
    assign bus.chan_id_o = id_out;

endmodule

// File: tb/tb_serial_link_enqueue_arbiter.sv
// Directed self-checking bench for serial_link_enqueue_arbiter (5 channels, StarveCycles=4).
module tb_serial_link_enqueue_arbiter;

    localparam int unsigned NumChan = 5;
    localparam int unsigned DW      = 64;
    localparam int unsigned SW      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_link_enqueue_arbiter_if #(
        .NumChan   (NumChan),
        .DataWidth (DW),
        .StrbWidth (SW)
    ) bus ();

    serial_link_enqueue_arbiter #(
        .NumChan      (NumChan),
        .DataWidth    (DW),
        .StrbWidth    (SW),
        .StarveCycles (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] exp_data(int c);
        return {32'hDA7A_0000, 24'h0, 8'(c)};
    endfunction

    function automatic logic [SW-1:0] exp_strb(int c);
        return 8'((c + 1) * 17);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic src(int c, logic v, logic l);
        bus.valid_i[c] = v;
        bus.last_i[c]  = l;
    endtask

    task automatic clear_src();
        bus.valid_i = '0;
        bus.last_i  = '0;
        for (int c = 0; c < NumChan; c++) begin
            bus.data_i[c*DW +: DW] = exp_data(c);
            bus.strb_i[c*SW +: SW] = exp_strb(c);
        end
        #1;
    endtask

    task automatic test_reset();
        bus.valid_i = '1;
        bus.last_i  = '1;
        bus.ready_i = 1'b1;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid got %b want 0", bus.valid_o);
        end
        checks++;
        if (bus.ready_o !== 5'b0) begin
            failures++; $display("FAIL reset_ready got %b want 00000", bus.ready_o);
        end
        checks++;
        if (bus.chan_id_o !== 3'd0 || bus.data_o !== 64'd0 || bus.strb_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_outs id=%0d data=%h strb=%h want all 0",
                     bus.chan_id_o, bus.data_o, bus.strb_o);
        end
        clear_src();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // rr_ptr=0 on entry; leaves rr_ptr=1.
    task automatic test_single_beat();
        src(0, 1, 1); src(2, 1, 1);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.chan_id_o !== 3'd0 || bus.ready_o !== 5'b00001) begin
            failures++;
            $display("FAIL sb_first v=%b id=%0d rdy=%b want 1/0/00001",
                     bus.valid_o, bus.chan_id_o, bus.ready_o);
        end
        checks++;
        if (bus.data_o !== exp_data(0) || bus.strb_o !== exp_strb(0)) begin
            failures++;
            $display("FAIL sb_data0 got %h/%h want %h/%h",
                     bus.data_o, bus.strb_o, exp_data(0), exp_strb(0));
        end
        tick();
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd2 || bus.ready_o !== 5'b00100) begin
            failures++;
            $display("FAIL sb_second id=%0d rdy=%b want 2/00100", bus.chan_id_o, bus.ready_o);
        end
        checks++;
        if (bus.data_o !== exp_data(2)) begin
            failures++; $display("FAIL sb_data2 got %h want %h", bus.data_o, exp_data(2));
        end
        tick();
        src(2, 0, 0); src(4, 1, 1);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd4 || bus.ready_o !== 5'b10000) begin
            failures++;
            $display("FAIL sb_ptr3 id=%0d rdy=%b want 4/10000", bus.chan_id_o, bus.ready_o);
        end
        tick();
        src(4, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd0 || bus.valid_o !== 1'b1) begin
            failures++; $display("FAIL sb_ptr0 id=%0d v=%b want 0/1", bus.chan_id_o, bus.valid_o);
        end
        tick();
        clear_src();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== 64'd0 || bus.chan_id_o !== 3'd0) begin
            failures++;
            $display("FAIL sb_idle v=%b data=%h id=%0d want 0/0/0",
                     bus.valid_o, bus.data_o, bus.chan_id_o);
        end
    endtask

    // rr_ptr=1 on entry; leaves rr_ptr=1.
    task automatic test_locked_packet();
        src(0, 1, 1); src(1, 1, 0);
        bus.data_i[1*DW +: DW] = 64'hB0B0_0000_0000_0001;
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd1 || bus.ready_o !== 5'b00010 ||
            bus.data_o !== 64'hB0B0_0000_0000_0001) begin
            failures++;
            $display("FAIL lk_beat1 id=%0d rdy=%b data=%h want 1/00010/b0b0..01",
                     bus.chan_id_o, bus.ready_o, bus.data_o);
        end
        tick();
        src(1, 0, 0);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 5'b00000) begin
            failures++;
            $display("FAIL lk_bubble v=%b rdy=%b want 0/00000", bus.valid_o, bus.ready_o);
        end
        tick();
        src(1, 1, 0);
        bus.data_i[1*DW +: DW] = 64'hB0B0_0000_0000_0002;
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd1 || bus.ready_o !== 5'b00010 ||
            bus.data_o !== 64'hB0B0_0000_0000_0002) begin
            failures++;
            $display("FAIL lk_beat2 id=%0d rdy=%b data=%h want 1/00010/b0b0..02",
                     bus.chan_id_o, bus.ready_o, bus.data_o);
        end
        tick();
        src(1, 1, 1);
        bus.data_i[1*DW +: DW] = 64'hB0B0_0000_0000_0003;
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd1 || bus.ready_o !== 5'b00010 ||
            bus.data_o !== 64'hB0B0_0000_0000_0003) begin
            failures++;
            $display("FAIL lk_beat3 id=%0d rdy=%b data=%h want 1/00010/b0b0..03",
                     bus.chan_id_o, bus.ready_o, bus.data_o);
        end
        tick();
        src(1, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd0 || bus.ready_o !== 5'b00001) begin
            failures++;
            $display("FAIL lk_release id=%0d rdy=%b want 0/00001", bus.chan_id_o, bus.ready_o);
        end
        tick();
        clear_src();
    endtask

    // rr_ptr=1 on entry; leaves rr_ptr=2.
    task automatic test_back_to_back();
        bus.ready_i = 1'b0;
        src(3, 1, 1); src(4, 1, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.chan_id_o !== 3'd3 || bus.data_o !== exp_data(3) ||
                bus.ready_o !== 5'b00000) begin
                failures++;
                $display("FAIL bp_stall%0d v=%b id=%0d data=%h rdy=%b want 1/3/%h/00000", i,
                         bus.valid_o, bus.chan_id_o, bus.data_o, bus.ready_o, exp_data(3));
            end
            tick();
            src(1, 1, 1);
        end
        bus.ready_i = 1'b1;
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd3 || bus.ready_o !== 5'b01000) begin
            failures++;
            $display("FAIL bp_accept id=%0d rdy=%b want 3/01000", bus.chan_id_o, bus.ready_o);
        end
        tick();
        src(3, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd4 || bus.ready_o !== 5'b10000) begin
            failures++;
            $display("FAIL bp_next id=%0d rdy=%b want 4/10000", bus.chan_id_o, bus.ready_o);
        end
        tick();
        src(4, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd1) begin
            failures++; $display("FAIL bp_after id=%0d want 1", bus.chan_id_o);
        end
        tick();
        clear_src();
    endtask

    // rr_ptr=2 on entry; leaves rr_ptr=1.
    task automatic test_wrap();
        src(3, 1, 1);
        tick();
        src(3, 0, 0); src(0, 1, 1); src(4, 1, 1);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd4 || bus.ready_o !== 5'b10000) begin
            failures++;
            $display("FAIL wrap_first id=%0d rdy=%b want 4/10000", bus.chan_id_o, bus.ready_o);
        end
        tick();
        src(4, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd0 || bus.ready_o !== 5'b00001) begin
            failures++;
            $display("FAIL wrap_second id=%0d rdy=%b want 0/00001", bus.chan_id_o, bus.ready_o);
        end
        tick();
        clear_src();
    endtask

    // rr_ptr=1 on entry; leaves rr_ptr=3.
    task automatic test_reset_mid_packet();
        src(2, 1, 0);
        tick();
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd2 || bus.ready_o !== 5'b00100) begin
            failures++;
            $display("FAIL rm_beat2 id=%0d rdy=%b want 2/00100", bus.chan_id_o, bus.ready_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 5'b00000) begin
            failures++;
            $display("FAIL rm_inreset v=%b rdy=%b want 0/00000", bus.valid_o, bus.ready_o);
        end
        tick();
        rst = 1'b0;
        clear_src();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 5'b00000) begin
            failures++;
            $display("FAIL rm_after v=%b rdy=%b want 0/00000", bus.valid_o, bus.ready_o);
        end
        src(0, 1, 1); src(2, 1, 1);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd0 || bus.ready_o !== 5'b00001) begin
            failures++;
            $display("FAIL rm_ptr0 id=%0d rdy=%b want 0/00001", bus.chan_id_o, bus.ready_o);
        end
        tick();
        src(0, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd2) begin
            failures++; $display("FAIL rm_idle id=%0d want 2", bus.chan_id_o);
        end
        tick();
        clear_src();
    endtask

`ifdef SERIAL_LINK_ARB_STARVE_EN
    task automatic test_starve();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src(0, 1, 0); src(2, 1, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) src(0, 1, 1);
            #1;
            checks++;
            if (bus.chan_id_o !== 3'd0) begin
                failures++; $display("FAIL st_long%0d id=%0d want 0", i, bus.chan_id_o);
            end
            tick();
        end
        src(0, 0, 0); src(1, 1, 1);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd2 || bus.ready_o !== 5'b00100) begin
            failures++;
            $display("FAIL st_boost id=%0d rdy=%b want 2/00100", bus.chan_id_o, bus.ready_o);
        end
        tick();
        src(2, 0, 0);
        #1;
        checks++;
        if (bus.chan_id_o !== 3'd1) begin
            failures++; $display("FAIL st_after id=%0d want 1", bus.chan_id_o);
        end
        tick();
        clear_src();
    endtask
`endif

    initial begin
        bus.ready_i = 1'b0;
        clear_src();
        tick();
        tick();
        test_reset();
        test_single_beat();
        test_locked_packet();
        test_back_to_back();
        test_wrap();
        test_reset_mid_packet();
`ifdef SERIAL_LINK_ARB_STARVE_EN
        test_starve();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
